cpu_mc_core: RTL and testbench
==============================

# cpu_mc_core

Parametrised multi-cycle successor to the team's 19-bit pipelined CPU. Single-issue core, fixed 5-state FSM per instruction, integrated unified program/data memory, a 16-entry register file and a bounded call stack. Adds overflow/underflow fault detection, HALT, store, and a program-load/debug port. Sits at the top of the processor tile; a testbench or loader drives it.

## Interface
- `DATA_W`, 19: register, memory and ALU width; must be ≥19. Instruction is the word's `[18:0]`.
- `MEM_DEPTH`, 1024: memory words; power of 2, ≤2048. `AW = clog2(MEM_DEPTH)`.
- `STACK_DEPTH`, 16: call-stack entries, ≥1.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: start/resume strobe, sampled only in IDLE or HALT.
- `prog_we` in 1: memory write strobe, honoured only in IDLE, HALT or FAULT.
- `prog_addr` in AW: load address.
- `prog_wdata` in DATA_W: load data.
- `dbg_raddr` in 4: debug register select.
- `dbg_rdata` out DATA_W: combinational `regs[dbg_raddr]`.
- `pc` out AW: current PC.
- `retire` out 1: 1-cycle pulse in each instruction's WB cycle.
- `halted` out 1: high in HALT.
- `fault` out 1: high in FAULT.
- `fault_code` out 2: 0 none, 1 stack overflow, 2 stack underflow; sticky until reset.

## Operation
- Fields: `op=[18:15]`, `r1=[14:11]`, `r2=[10:7]`, `r3=[6:3]`, `addr=[10:0]` (low AW bits used, zero-extended if AW>11), `off=[6:0]` signed.
- Opcodes:
  - 0 LD: `r1←mem[addr]`
  - 1 ADD: `r1←r2+r3`
  - 2 SUB: `r1←r2-r3`
  - 3 MUL: `r1←low DATA_W of r2*r3`
  - 4 ST: `mem[addr]←r1`
  - 5 INC: `r1←r2+1`
  - 6 DEC: `r1←r2-1`
  - 7 AND, 8 OR, 9 XOR: `r1←r2 op r3`
  - A NOT: `r1←~r2`
  - B JMP: `pc←addr`
  - C BEQ: if `r1==r2`, `pc←pc+1+sext(off)`
  - D BNE: if `r1!=r2`, `pc←pc+1+sext(off)`
  - E CALL: push `pc+1`, `pc←addr`
  - F: `[14]=1` HALT, else RET (pop into pc).
- All arithmetic wraps modulo 2^DATA_W. PC arithmetic wraps modulo MEM_DEPTH.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
  - IDLE –run→ FETCH.
  - FETCH → DECODE → EXEC.
  - EXEC → MEM, except → FAULT on an overflowing CALL or underflowing RET, and → HALT on HALT.
  - MEM → WB → FETCH.
  - HALT –run→ FETCH.
  - FAULT exits only on reset.
- FETCH issues `mem[pc]` (synchronous read). DECODE latches the instruction and reads the registers. EXEC computes the ALU result, branch decision, stack operation and next PC, and writes `pc` at the end of EXEC (default `pc+1`). MEM performs the LD read or ST write. WB writes `r1` for LD and opcodes 1–3 and 5–A, and pulses `retire`.
- Stack: `sp` counts entries 0..STACK_DEPTH.
  - CALL with `sp==STACK_DEPTH` → overflow fault; no push, pc unchanged.
  - RET with `sp==0` → underflow fault.
- HALT: pc already advanced by EXEC, so resume continues at the next instruction; `retire` is not pulsed.
- `prog_we` outside the permitted states is ignored. `run` outside IDLE/HALT is ignored. r0 is an ordinary register.

## Timing
- Reset values: state IDLE, `pc=0`, `sp=0`, all regs 0, `retire=0`, `halted=0`, `fault=0`, `fault_code=0`. Memory contents are not reset.
- `run` high at edge N in IDLE → FETCH in cycle N+1; that instruction's `retire` pulses in cycle N+5; the next FETCH is in N+6. CPI is fixed at 5.
- `pc` updates on the EXEC→MEM edge.
- `halted`/`fault` assert in the cycle after EXEC of the HALT/faulting instruction.
- `reset` mid-instruction: the next cycle is IDLE with all reset values. A pending ST that had not reached MEM does not write.
- A `prog_we` write is visible to a FETCH or LD issued one cycle later or more.

## Structure
- `cpu_pkg`: opcode localparams, FSM state enum, fault-code constants, field-slice helper functions.
- Sub-module `cpu_alu`: combinational, parametrised on DATA_W; inputs op, a, b; output result.
- Memory, register file and stack are inferred arrays inside `cpu_mc_core`.

## Test plan
- ADD: load `R2=5`, `R3=7` via LD, then ADD R1,R2,R3, then HALT → `dbg_rdata(R1)=12`, 3 `retire` pulses, `halted=1`.
- BNE loop: R1 counts down from 3 via DEC, BNE back with `off=-2` → loop exits with `R1=0`, `pc` = instruction after the BNE.
- CALL/RET: CALL to 0x100 holding INC R4,R4 then RET → returns to CALL+1, `R4=1`, `sp` back to 0.
- Overflow (STACK_DEPTH=2): three nested CALLs → `fault=1`, `fault_code=1`; further `run` is ignored.
- Underflow: RET first → `fault_code=2`. Separately, ST R1→0x3FF then LD R5←0x3FF → `R5==R1`.
- Robustness: assert `reset` in EXEC of an ST → location unchanged, state IDLE. A `prog_we` pulse during FETCH → memory unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states,
// fault codes and instruction field helpers.
package cpu_pkg;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_INC  = 4'h5;
    localparam logic [3:0] OP_DEC  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_BNE  = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hE;
    localparam logic [3:0] OP_SYS  = 4'hF;

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_OVF  = 2'd1;
    localparam logic [1:0] FC_UNF  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC,
        S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    function automatic logic [3:0] f_op(input logic [18:0] i);
        return i[18:15];
    endfunction

    function automatic logic [3:0] f_r1(input logic [18:0] i);
        return i[14:11];
    endfunction

    function automatic logic [3:0] f_r2(input logic [18:0] i);
        return i[10:7];
    endfunction

    function automatic logic [3:0] f_r3(input logic [18:0] i);
        return i[6:3];
    endfunction

    // Opcodes that write r1 in WB: LD, 1-3 and 5-A.
    function automatic logic writes_r1(input logic [3:0] op);
        return (op == OP_LD) || (op >= OP_ADD && op <= OP_MUL) ||
               (op >= OP_INC && op <= OP_NOT);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU. Ports: op (opcode), a/b (operands), result.
// Non-ALU opcodes produce zero; all arithmetic wraps at DATA_W.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 19
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_INC:  result = a + DATA_W'(1);
            OP_DEC:  result = a - DATA_W'(1);
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/cpu_mc_core.sv
// Multi-cycle core: 5-state instruction FSM, unified memory, 16 regs,
// bounded call stack. Ports: clk/reset, run, prog_* loader, dbg_* reg
// read, pc, retire, halted, fault, fault_code.
module cpu_mc_core
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 19,
    parameter int MEM_DEPTH   = 1024,
    parameter int STACK_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic                         prog_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]            prog_wdata,
    input  logic [3:0]                   dbg_raddr,
    output logic [DATA_W-1:0]            dbg_rdata,
    output logic [$clog2(MEM_DEPTH)-1:0] pc,
    output logic                         retire,
    output logic                         halted,
    output logic                         fault,
    output logic [1:0]                   fault_code
);

    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    state_t            state;
    logic [DATA_W-1:0] mem   [MEM_DEPTH];
    logic [DATA_W-1:0] regs  [16];
    // One spare slot so sp (0..STACK_DEPTH) indexes without narrowing.
    logic [AW-1:0]     stack [STACK_DEPTH+1];
    logic [SPW-1:0]    sp;

    logic [18:0]       ir;
    logic [DATA_W-1:0] mem_q, rd1, rd2, rd3, res, alu_y;
    logic [3:0]        op;
    logic [AW-1:0]     ir_addr, off_ext, pc_inc, br_tgt;
    logic              is_st, is_ld, prog_ok, stk_full, stk_empty;

    assign op        = f_op(ir);
    assign ir_addr   = ir[AW-1:0];
    assign off_ext   = AW'($signed(ir[6:0]));
    assign pc_inc    = pc + AW'(1);
    assign br_tgt    = pc_inc + off_ext;
    assign is_st     = (op == OP_ST);
    assign is_ld     = (op == OP_LD);
    assign stk_full  = (sp == SPW'(STACK_DEPTH));
    assign stk_empty = (sp == '0);
    assign prog_ok   = (state == S_IDLE) || (state == S_HALT) ||
                       (state == S_FAULT);
    assign dbg_rdata = regs[dbg_raddr];

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (rd2),
        .b      (rd3),
        .result (alu_y)
    );

    // Memory: no reset so it maps onto block RAM. The same port serves
    // instruction fetch and LD, which never overlap in time.
    always_ff @(posedge clk) begin
        if (state == S_MEM && is_st && !reset)
            mem[ir_addr] <= rd1;
        else if (prog_we && prog_ok)
            mem[prog_addr] <= prog_wdata;
        if (state == S_FETCH)
            mem_q <= mem[pc];
        else if (state == S_MEM)
            mem_q <= mem[ir_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            sp         <= '0;
            ir         <= '0;
            rd1        <= '0;
            rd2        <= '0;
            rd3        <= '0;
            res        <= '0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (run)
                        state <= S_FETCH;
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir    <= mem_q[18:0];
                    rd1   <= regs[f_r1(mem_q[18:0])];
                    rd2   <= regs[f_r2(mem_q[18:0])];
                    rd3   <= regs[f_r3(mem_q[18:0])];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res   <= alu_y;
                    pc    <= pc_inc;
                    state <= S_MEM;
                    case (op)
                        OP_JMP: pc <= ir_addr;
                        OP_BEQ: if (rd1 == rd2) pc <= br_tgt;
                        OP_BNE: if (rd1 != rd2) pc <= br_tgt;
                        OP_CALL: begin
                            if (stk_full) begin
                                pc         <= pc;
                                fault      <= 1'b1;
                                fault_code <= FC_OVF;
                                state      <= S_FAULT;
                            end else begin
                                stack[sp] <= pc_inc;
                                sp        <= sp + SPW'(1);
                                pc        <= ir_addr;
                            end
                        end
                        OP_SYS: begin
                            if (ir[14]) begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end else if (stk_empty) begin
                                pc         <= pc;
                                fault      <= 1'b1;
                                fault_code <= FC_UNF;
                                state      <= S_FAULT;
                            end else begin
                                pc <= stack[sp - SPW'(1)];
                                sp <= sp - SPW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    retire <= 1'b1;
                    state  <= S_WB;
                end
                S_WB: begin
                    if (writes_r1(op))
                        regs[f_r1(ir)] <= is_ld ? mem_q : res;
                    state <= S_FETCH;
                end
                S_HALT: begin
                    if (run) begin
                        halted <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                S_FAULT: state <= S_FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mc_core.sv
// Directed self-checking bench for cpu_mc_core.
// Small programs are loaded through the prog port and run to HALT/FAULT.
module tb_cpu_mc_core;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [9:0]  prog_addr = '0;
    logic [18:0] prog_wdata = '0;
    logic [3:0]  dbg_raddr = '0;
    logic [18:0] dbg_rdata;
    logic [9:0]  pc;
    logic        retire, halted, fault;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;
    int ret_cnt = 0;
    int base;

    cpu_mc_core #(.DATA_W(19), .MEM_DEPTH(1024), .STACK_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .run(run),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc(pc),
        .retire(retire), .halted(halted), .fault(fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (retire === 1'b1) ret_cnt <= ret_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] r,
                             input logic [18:0] exp);
        dbg_raddr = r;
        #1;
        check(tag, {13'b0, dbg_rdata}, {13'b0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic load(input logic [9:0] a, input logic [18:0] d);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic wait_stop();
        int n;
        n = 0;
        while (!(halted || fault) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("stop_timeout", {31'b0, halted | fault}, 32'd1);
    endtask

    function automatic logic [18:0] i3(input logic [3:0] op,
        input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 3'b000};
    endfunction

    function automatic logic [18:0] ia(input logic [3:0] op,
        input logic [3:0] a, input logic [10:0] ad);
        return {op, a, ad};
    endfunction

    function automatic logic [18:0] ib(input logic [3:0] op,
        input logic [3:0] a, input logic [3:0] b, input logic [6:0] off);
        return {op, a, b, off};
    endfunction

    localparam logic [18:0] HALT = 19'h7C000;
    localparam logic [18:0] RET  = 19'h78000;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_pc", {22'b0, pc}, 32'd0);
        check("rst_retire", {31'b0, retire}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_fcode", {30'b0, fault_code}, 32'd0);
        check("rst_state", {29'b0, dut.state}, {29'b0, S_IDLE});
        check_reg("rst_r1", 4'd1, 19'd0);

        // ADD program with CPI timing
        load(10'h200, 19'd5);
        load(10'h201, 19'd7);
        load(10'd0, ia(OP_LD, 4'd2, 11'h200));
        load(10'd1, ia(OP_LD, 4'd3, 11'h201));
        load(10'd2, i3(OP_ADD, 4'd1, 4'd2, 4'd3));
        load(10'd3, HALT);
        base = ret_cnt;
        start();
        repeat (3) @(posedge clk);
        #1;
        check("retire_early", {31'b0, retire}, 32'd0);
        @(posedge clk); #1;
        check("retire_n5", {31'b0, retire}, 32'd1);
        check("pc_after_exec", {22'b0, pc}, 32'd1);
        wait_stop();
        check("add_halted", {31'b0, halted}, 32'd1);
        check_reg("add_r1", 4'd1, 19'd12);
        check("add_retires", ret_cnt - base, 32'd3);
        check("add_pc", {22'b0, pc}, 32'd4);

        // Resume from HALT, loading while halted
        load(10'd4, i3(OP_INC, 4'd6, 4'd6, 4'd0));
        load(10'd5, HALT);
        start();
        check("resume_halted_clr", {31'b0, halted}, 32'd0);
        wait_stop();
        check_reg("resume_r6", 4'd6, 19'd1);
        check("resume_pc", {22'b0, pc}, 32'd6);

        // BNE countdown loop
        do_reset();
        load(10'h200, 19'd3);
        load(10'd0, ia(OP_LD, 4'd1, 11'h200));
        load(10'd1, i3(OP_DEC, 4'd1, 4'd1, 4'd0));
        load(10'd2, ib(OP_BNE, 4'd1, 4'd0, 7'h7E));
        load(10'd3, HALT);
        base = ret_cnt;
        start();
        wait_stop();
        check_reg("bne_r1", 4'd1, 19'd0);
        check("bne_retires", ret_cnt - base, 32'd7);
        check("bne_pc", {22'b0, pc}, 32'd4);

        // CALL / RET
        do_reset();
        load(10'd0, ia(OP_CALL, 4'd0, 11'h100));
        load(10'd1, HALT);
        load(10'h100, i3(OP_INC, 4'd4, 4'd4, 4'd0));
        load(10'h101, RET);
        base = ret_cnt;
        start();
        wait_stop();
        check("call_halted", {31'b0, halted}, 32'd1);
        check_reg("call_r4", 4'd4, 19'd1);
        check("call_pc", {22'b0, pc}, 32'd2);
        check("call_sp", {30'b0, dut.sp}, 32'd0);
        check("call_retires", ret_cnt - base, 32'd3);

        // Stack overflow with depth 2
        do_reset();
        load(10'd0, ia(OP_CALL, 4'd0, 11'h010));
        load(10'h010, ia(OP_CALL, 4'd0, 11'h020));
        load(10'h020, ia(OP_CALL, 4'd0, 11'h030));
        base = ret_cnt;
        start();
        wait_stop();
        check("ovf_fault", {31'b0, fault}, 32'd1);
        check("ovf_code", {30'b0, fault_code}, 32'd1);
        check("ovf_halted", {31'b0, halted}, 32'd0);
        check("ovf_pc", {22'b0, pc}, 32'h20);
        check("ovf_sp", {30'b0, dut.sp}, 32'd2);
        start();
        repeat (8) @(posedge clk);
        #1;
        check("ovf_run_ign", {29'b0, dut.state}, {29'b0, S_FAULT});
        check("ovf_pc_hold", {22'b0, pc}, 32'h20);
        check("ovf_retires", ret_cnt - base, 32'd2);

        // Stack underflow
        do_reset();
        load(10'd0, RET);
        start();
        wait_stop();
        check("unf_fault", {31'b0, fault}, 32'd1);
        check("unf_code", {30'b0, fault_code}, 32'd2);
        check("unf_pc", {22'b0, pc}, 32'd0);

        // ST then LD at top of memory
        do_reset();
        check("rst_fcode_clr", {30'b0, fault_code}, 32'd0);
        load(10'h200, 19'h5A5A5);
        load(10'd0, ia(OP_LD, 4'd1, 11'h200));
        load(10'd1, ia(OP_ST, 4'd1, 11'h3FF));
        load(10'd2, ia(OP_LD, 4'd5, 11'h3FF));
        load(10'd3, HALT);
        start();
        wait_stop();
        check_reg("stld_r5", 4'd5, 19'h5A5A5);
        check("stld_mem", {13'b0, dut.mem[10'h3FF]}, 32'h5A5A5);

        // ALU ops, BEQ skip, JMP
        do_reset();
        load(10'h200, 19'd6);
        load(10'h201, 19'h7FFFD);
        load(10'd0, ia(OP_LD, 4'd2, 11'h200));
        load(10'd1, ia(OP_LD, 4'd3, 11'h201));
        load(10'd2, i3(OP_SUB, 4'd7, 4'd2, 4'd3));
        load(10'd3, i3(OP_MUL, 4'd8, 4'd2, 4'd3));
        load(10'd4, i3(OP_AND, 4'd9, 4'd2, 4'd3));
        load(10'd5, i3(OP_OR, 4'd10, 4'd2, 4'd3));
        load(10'd6, i3(OP_XOR, 4'd11, 4'd2, 4'd3));
        load(10'd7, i3(OP_NOT, 4'd12, 4'd2, 4'd0));
        load(10'd8, i3(OP_DEC, 4'd13, 4'd0, 4'd0));
        load(10'd9, ib(OP_BEQ, 4'd2, 4'd2, 7'd1));
        load(10'd10, i3(OP_INC, 4'd14, 4'd14, 4'd0));
        load(10'd11, ia(OP_JMP, 4'd0, 11'h040));
        load(10'h040, HALT);
        base = ret_cnt;
        start();
        wait_stop();
        check_reg("alu_sub", 4'd7, 19'd9);
        check_reg("alu_mul", 4'd8, 19'h7FFEE);
        check_reg("alu_and", 4'd9, 19'd4);
        check_reg("alu_or", 4'd10, 19'h7FFFF);
        check_reg("alu_xor", 4'd11, 19'h7FFFB);
        check_reg("alu_not", 4'd12, 19'h7FFF9);
        check_reg("alu_dec_wrap", 4'd13, 19'h7FFFF);
        check_reg("beq_skip", 4'd14, 19'd0);
        check("jmp_pc", {22'b0, pc}, 32'h41);
        check("alu_retires", ret_cnt - base, 32'd11);

        // Reset during EXEC of a store
        do_reset();
        load(10'h300, 19'h11111);
        load(10'h301, 19'h33333);
        load(10'd0, ia(OP_ST, 4'd1, 11'h300));
        start();
        repeat (2) @(posedge clk);
        #1;
        check("st_in_exec", {29'b0, dut.state}, {29'b0, S_EXEC});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_exec_state", {29'b0, dut.state}, {29'b0, S_IDLE});
        check("rst_exec_pc", {22'b0, pc}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_exec_mem", {13'b0, dut.mem[10'h300]}, 32'h11111);

        // prog_we during FETCH is ignored
        start();
        prog_we = 1'b1; prog_addr = 10'h301; prog_wdata = 19'h22222;
        @(posedge clk); #1;
        prog_we = 1'b0;
        check("fetch_we_ign", {13'b0, dut.mem[10'h301]}, 32'h33333);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
